// File: rtl/rv32i_types.sv
// Shared RV32I datapath types: jump kinds, branch-resolve FSM states and PC step.
package rv32i_types;

    typedef enum logic [1:0] {
        J_NONE   = 2'd0,
        J_BRANCH = 2'd1,
        J_JAL    = 2'd2,
        J_JALR   = 2'd3
    } jump_kind_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        TRAP = 2'd2
    } branch_resolve_state_t;

    localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/branch_target_calc.sv
// Combinational control-transfer target, taken flag and misalignment detect.
module branch_target_calc
    import rv32i_types::*;
(
    input  jump_kind_t  jump_kind,
    input  logic        cmp_out,
    input  logic [31:0] pc,
    input  logic [31:0] rs1,
    input  logic [31:0] imm,
    output logic [31:0] target,
    output logic        taken,
    output logic        misaligned
);

    always_comb begin
        target = pc + PC_STEP;
        taken  = 1'b0;
        case (jump_kind)
            J_BRANCH: begin
                taken = cmp_out;
                if (cmp_out) target = pc + imm;
            end
            J_JAL: begin
                taken  = 1'b1;
                target = pc + imm;
            end
            J_JALR: begin
                taken  = 1'b1;
                target = (rs1 + imm) & ~32'h1;
            end
            default: ;
        endcase
    end

    // Only a taken transfer can fault; the fall-through target is never fetched from here.
    assign misaligned = taken & target[1];

endmodule

// File: rtl/branch_resolve.sv
// Registered next-PC redirect with valid/ready hold and misaligned-target trap.
// Optional taken/resolved counters are built when BRANCH_STATS_EN is defined.
module branch_resolve
    import rv32i_types::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0060
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        resolve_valid,
    output logic        resolve_ready,
    input  jump_kind_t  jump_kind,
    input  logic        cmp_out,
    input  logic [31:0] pc,
    input  logic [31:0] rs1,
    input  logic [31:0] imm,
    output logic        redirect_valid,
    input  logic        redirect_ready,
    output logic [31:0] redirect_pc,
    output logic        redirect_taken,
    output logic [31:0] link_addr,
    output logic        trap_valid,
    output logic [31:0] trap_addr,
    input  logic        trap_ack,
    output logic [31:0] stat_taken,
    output logic [31:0] stat_resolved
);

    branch_resolve_state_t state;

    logic [31:0] calc_target;
    logic        calc_taken;
    logic        calc_misaligned;

    logic        ready_q;
    logic        valid_q;
    logic        trap_q;
    logic [31:0] pc_q;
    logic [31:0] link_q;
    logic [31:0] trap_addr_q;
    logic        taken_q;

    branch_target_calc u_calc (
        .jump_kind  (jump_kind),
        .cmp_out    (cmp_out),
        .pc         (pc),
        .rs1        (rs1),
        .imm        (imm),
        .target     (calc_target),
        .taken      (calc_taken),
        .misaligned (calc_misaligned)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ready_q     <= 1'b1;
            valid_q     <= 1'b0;
            trap_q      <= 1'b0;
            pc_q        <= RESET_PC;
            link_q      <= '0;
            trap_addr_q <= '0;
            taken_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (resolve_valid && ready_q) begin
                        ready_q <= 1'b0;
                        link_q  <= pc + PC_STEP;
                        taken_q <= calc_taken;
                        if (calc_misaligned) begin
                            state       <= TRAP;
                            trap_q      <= 1'b1;
                            trap_addr_q <= calc_target;
                        end else begin
                            state   <= HOLD;
                            valid_q <= 1'b1;
                            pc_q    <= calc_target;
                        end
                    end
                end
                HOLD: begin
                    if (redirect_ready) begin
                        state   <= IDLE;
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                TRAP: begin
                    if (trap_ack) begin
                        state   <= IDLE;
                        trap_q  <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    ready_q <= 1'b1;
                    valid_q <= 1'b0;
                    trap_q  <= 1'b0;
                end
            endcase
        end
    end

    assign resolve_ready  = ready_q;
    assign redirect_valid = valid_q;
    assign redirect_pc    = pc_q;
    assign redirect_taken = taken_q;
    assign link_addr      = link_q;
    assign trap_valid     = trap_q;
    assign trap_addr      = trap_addr_q;

`ifdef BRANCH_STATS_EN
    logic        accept;
    logic [31:0] stat_taken_q;
    logic [31:0] stat_resolved_q;

    assign accept = resolve_valid && ready_q;

    // Saturating counters: trapping transfers still count as taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_taken_q    <= '0;
            stat_resolved_q <= '0;
        end else if (accept) begin
            if (stat_resolved_q != 32'hFFFF_FFFF) stat_resolved_q <= stat_resolved_q + 32'd1;
            if (calc_taken && stat_taken_q != 32'hFFFF_FFFF) stat_taken_q <= stat_taken_q + 32'd1;
        end
    end

    assign stat_taken    = stat_taken_q;
    assign stat_resolved = stat_resolved_q;
`else
    assign stat_taken    = '0;
    assign stat_resolved = '0;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Directed self-checking bench for branch_resolve; stats expectations follow BRANCH_STATS_EN.
module tb_branch_resolve;
    import rv32i_types::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        resolve_valid;
    logic        resolve_ready;
    jump_kind_t  jump_kind;
    logic        cmp_out;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] imm;
    logic        redirect_valid;
    logic        redirect_ready;
    logic [31:0] redirect_pc;
    logic        redirect_taken;
    logic [31:0] link_addr;
    logic        trap_valid;
    logic [31:0] trap_addr;
    logic        trap_ack;
    logic [31:0] stat_taken;
    logic [31:0] stat_resolved;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    branch_resolve #(.RESET_PC(32'h0000_0060)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .resolve_valid  (resolve_valid),
        .resolve_ready  (resolve_ready),
        .jump_kind      (jump_kind),
        .cmp_out        (cmp_out),
        .pc             (pc),
        .rs1            (rs1),
        .imm            (imm),
        .redirect_valid (redirect_valid),
        .redirect_ready (redirect_ready),
        .redirect_pc    (redirect_pc),
        .redirect_taken (redirect_taken),
        .link_addr      (link_addr),
        .trap_valid     (trap_valid),
        .trap_addr      (trap_addr),
        .trap_ack       (trap_ack),
        .stat_taken     (stat_taken),
        .stat_resolved  (stat_resolved)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one request for exactly one rising edge, then sample at the next falling edge.
    task automatic issue(input jump_kind_t k, input logic c, input logic [31:0] p,
                         input logic [31:0] r, input logic [31:0] i);
        resolve_valid = 1'b1;
        jump_kind     = k;
        cmp_out       = c;
        pc            = p;
        rs1           = r;
        imm           = i;
        @(negedge clk);
        resolve_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_taken;
        logic [31:0] exp_resolved;
`ifdef BRANCH_STATS_EN
        exp_taken    = 32'd3;
        exp_resolved = 32'd5;
`else
        exp_taken    = 32'd0;
        exp_resolved = 32'd0;
`endif
        rst_n          = 1'b0;
        resolve_valid  = 1'b0;
        jump_kind      = J_NONE;
        cmp_out        = 1'b0;
        pc             = '0;
        rs1            = '0;
        imm            = '0;
        redirect_ready = 1'b0;
        trap_ack       = 1'b0;

        #12;
        chk("rst_resolve_ready", 32'(resolve_ready), 32'd1);
        chk("rst_redirect_valid", 32'(redirect_valid), 32'd0);
        chk("rst_trap_valid", 32'(trap_valid), 32'd0);
        chk("rst_redirect_pc", redirect_pc, 32'h60);
        chk("rst_link_addr", link_addr, 32'h0);
        chk("rst_trap_addr", trap_addr, 32'h0);
        chk("rst_taken", 32'(redirect_taken), 32'd0);
        chk("rst_stat_taken", stat_taken, 32'd0);
        chk("rst_stat_resolved", stat_resolved, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Taken branch, fetch ready immediately.
        redirect_ready = 1'b1;
        issue(J_BRANCH, 1'b1, 32'h100, 32'h0, 32'h20);
        chk("br_taken_valid", 32'(redirect_valid), 32'd1);
        chk("br_taken_pc", redirect_pc, 32'h120);
        chk("br_taken_taken", 32'(redirect_taken), 32'd1);
        chk("br_taken_link", link_addr, 32'h104);
        chk("br_taken_busy", 32'(resolve_ready), 32'd0);
        @(negedge clk);
        chk("br_taken_done_valid", 32'(redirect_valid), 32'd0);
        chk("br_taken_done_ready", 32'(resolve_ready), 32'd1);
        chk("br_taken_pc_kept", redirect_pc, 32'h120);

        // Not-taken branch with a misaligned unused target.
        issue(J_BRANCH, 1'b0, 32'h100, 32'h0, 32'h22);
        chk("br_nt_valid", 32'(redirect_valid), 32'd1);
        chk("br_nt_pc", redirect_pc, 32'h104);
        chk("br_nt_taken", 32'(redirect_taken), 32'd0);
        chk("br_nt_no_trap", 32'(trap_valid), 32'd0);
        @(negedge clk);
        chk("br_nt_done", 32'(resolve_ready), 32'd1);

        // JALR with fetch stalled for three cycles.
        redirect_ready = 1'b0;
        issue(J_JALR, 1'b0, 32'h200, 32'h2001, 32'h4);
        for (int n = 0; n < 3; n++) begin
            chk("jalr_hold_valid", 32'(redirect_valid), 32'd1);
            chk("jalr_hold_pc", redirect_pc, 32'h2004);
            chk("jalr_hold_link", link_addr, 32'h204);
            chk("jalr_hold_taken", 32'(redirect_taken), 32'd1);
            chk("jalr_hold_busy", 32'(resolve_ready), 32'd0);
            @(negedge clk);
        end
        trap_ack = 1'b1;
        chk("jalr_ack_ignored", 32'(redirect_valid), 32'd1);
        trap_ack = 1'b0;
        redirect_ready = 1'b1;
        @(negedge clk);
        chk("jalr_done_valid", 32'(redirect_valid), 32'd0);
        chk("jalr_done_ready", 32'(resolve_ready), 32'd1);

        // Misaligned JAL traps; redirect_ready in TRAP must be ignored.
        issue(J_JAL, 1'b0, 32'h100, 32'h0, 32'h6);
        chk("jal_trap_valid", 32'(trap_valid), 32'd1);
        chk("jal_trap_addr", trap_addr, 32'h106);
        chk("jal_trap_no_redirect", 32'(redirect_valid), 32'd0);
        chk("jal_trap_busy", 32'(resolve_ready), 32'd0);
        @(negedge clk);
        chk("jal_trap_ready_ignored", 32'(trap_valid), 32'd1);
        redirect_ready = 1'b0;
        trap_ack = 1'b1;
        @(negedge clk);
        trap_ack = 1'b0;
        chk("jal_trap_cleared", 32'(trap_valid), 32'd0);
        chk("jal_trap_idle", 32'(resolve_ready), 32'd1);
        chk("jal_trap_no_redirect2", 32'(redirect_valid), 32'd0);

        // J_NONE at top of address space wraps to zero; reset aborts the hold.
        issue(J_NONE, 1'b1, 32'hFFFF_FFFC, 32'h0, 32'h40);
        chk("wrap_valid", 32'(redirect_valid), 32'd1);
        chk("wrap_pc", redirect_pc, 32'h0);
        chk("wrap_taken", 32'(redirect_taken), 32'd0);
        chk("wrap_link", link_addr, 32'h0);
        chk("stat_taken", stat_taken, exp_taken);
        chk("stat_resolved", stat_resolved, exp_resolved);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(redirect_valid), 32'd0);
        chk("mid_rst_pc", redirect_pc, 32'h60);
        chk("mid_rst_ready", 32'(resolve_ready), 32'd1);
        chk("mid_rst_stat_taken", stat_taken, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        redirect_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("post_rst_no_redirect", 32'(redirect_valid), 32'd0);
        chk("post_rst_no_trap", 32'(trap_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_resolve.md
Name: branch_resolve

Overview:
- Consumes the branch comparator's cmp_out and turns a branch/jump decision into a registered next-PC redirect for the fetch/PC-load logic of the multicycle RV32I datapath.
- Computes the branch, JAL and JALR targets and the link address.
- Detects misaligned targets. Without the C extension, a target with bit 1 set is illegal.
- Holds each result under a valid/ready handshake until fetch accepts it, or until control acknowledges a trap.

Parameters:
- RESET_PC, 32'h0000_0060: value driven on redirect_pc while in reset.

Ports:
- clk  in  1: system clock, rising edge.
- rst_n  in  1: asynchronous active-low reset.
- resolve_valid  in  1: control presents a control-transfer request this cycle.
- resolve_ready  out  1: block can accept a request.
- jump_kind  in  jump_kind_t (2): J_NONE, J_BRANCH, J_JAL, J_JALR.
- cmp_out  in  1: comparator result; meaningful only for J_BRANCH.
- pc  in  32: PC of the resolving instruction.
- rs1  in  32: rs1 value, used for JALR.
- imm  in  32: sign-extended immediate (B, J or I form, selected by control).
- redirect_valid  out  1: redirect_pc is valid.
- redirect_ready  in  1: fetch accepts the redirect.
- redirect_pc  out  32: next PC.
- redirect_taken  out  1: 1 if the control transfer was taken.
- link_addr  out  32: pc+4, registered with the request.
- trap_valid  out  1: misaligned-target trap pending.
- trap_addr  out  32: offending target.
- trap_ack  in  1: control consumed the trap.
- stat_taken  out  32: count of taken transfers (optional feature).
- stat_resolved  out  32: count of resolved requests (optional feature).

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE, resolve_ready=1, redirect_valid=0, trap_valid=0.
  - redirect_pc=RESET_PC; link_addr, trap_addr, redirect_taken and stats = 0.
- Target computation (combinational, all arithmetic modulo 2^32, wrap-around silent):
  - J_BRANCH: pc+imm if cmp_out, else pc+4.
  - J_JAL: pc+imm.
  - J_JALR: (rs1+imm) & ~32'h1.
  - J_NONE: pc+4, taken=0.
- Acceptance: a request is accepted when resolve_valid && resolve_ready. Inputs are sampled on that edge only.
- FSM states: IDLE, HOLD, TRAP.
  - IDLE, accepted with target[1]=1 and taken -> TRAP. trap_valid=1, trap_addr=target, redirect_valid stays 0.
  - IDLE, accepted otherwise -> HOLD. redirect_valid=1 on the following cycle (latency 1). redirect_pc, redirect_taken and link_addr are registered.
  - HOLD: outputs stable while redirect_ready=0. On redirect_ready=1 -> IDLE, redirect_valid=0 next cycle. redirect_pc keeps its last value.
  - TRAP: on trap_ack -> IDLE and trap_valid clears. A not-taken branch never traps, even if its unused target is misaligned.
- resolve_ready = (state==IDLE). There is no same-cycle pass-through: at most one request per two cycles.
- An input asserted in the wrong state is ignored: redirect_ready while not in HOLD, or trap_ack while not in TRAP.
- Reset mid-HOLD or mid-TRAP aborts the pending result; nothing is delivered afterwards.

Optional Feature:
- Macro BRANCH_STATS_EN.
- Defined:
  - stat_resolved increments on each accepted request.
  - stat_taken increments on each accepted request with taken=1, including trapping ones.
  - Both counters saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: both outputs are tied to 0 and no counter flops are built.

Decomposition:
- rv32i_types package additions:
  - jump_kind_t enum.
  - branch_resolve_state_t enum (IDLE, HOLD, TRAP).
  - constant PC_STEP = 32'd4.
- One sub-module, branch_target_calc: combinational target, taken and misaligned computation from jump_kind, cmp_out, pc, rs1 and imm. Testable in isolation.

Test Plan:
- Taken branch: pc=0x100, imm=0x20, J_BRANCH, cmp_out=1, redirect_ready=1 -> one cycle later redirect_valid=1, redirect_pc=0x120, taken=1, link_addr=0x104; next cycle IDLE, resolve_ready=1.
- Not-taken branch with imm=0x22: cmp_out=0 -> redirect_pc=0x104, taken=0, no trap.
- JALR: rs1=0x2001, imm=0x4 -> redirect_pc=0x2004 (bit 0 cleared). Hold redirect_ready=0 for 3 cycles -> outputs stable and resolve_ready=0 throughout.
- Misaligned JAL: pc=0x100, imm=0x6 -> trap_valid=1, trap_addr=0x106, redirect_valid=0. trap_ack -> IDLE next cycle.
- Wrap: pc=0xFFFF_FFFC, J_NONE -> redirect_pc=0x0. rst_n pulsed low during HOLD -> redirect_valid=0 immediately and redirect_pc=RESET_PC.
- BRANCH_STATS_EN: 3 taken plus 2 not-taken requests -> stat_taken=3, stat_resolved=5. With the macro undefined, both read 0.
